dmem_ctrl: RTL and testbench

Data-memory access controller directly downstream of the data-memory address decoder. Consumes the decoder's registered chip select (active-low), 10-bit window offset and write enable, and performs byte, halfword and word loads and stores on a 256 x 32 synchronous RAM. Sub-word stores use a read-modify-write sequence. Loads return sign- or zero-extended data to the CPU with a done strobe.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_ctrl_if.sv | 20 ++
 rtl/dmem_ram.sv | 18 +
 rtl/dmem_ctrl.sv | 123 ++++++++++++
 tb/tb_dmem_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;
  localparam int ADDR_W = 10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_FIN
  } state_e;

  // Size 2'b11 is handled as a word access.
  function automatic logic misaligned(logic [1:0] size, logic [1:0] lane);
    if (size == SZ_BYTE) return 1'b0;
    if (size == SZ_HALF) return lane[0];
    return lane != 2'b00;
  endfunction
endpackage

// File: rtl/dmem_ctrl_if.sv
// CPU-side access bus of the data-memory controller.
interface dmem_ctrl_if;
  import dmem_pkg::*;
  logic              req;
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic              uns;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              done;
  logic              busy;
  logic              err;

  modport master (output req, cs, we, addr, size, uns, wdata,
                  input  rdata, done, busy, err);
  modport slave  (input  req, cs, we, addr, size, uns, wdata,
                  output rdata, done, busy, err);
endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 1-cycle read latency, read-first.
module dmem_ram #(
  parameter int WORDS = 256,
  localparam int IW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/dmem_ctrl.sv
// Byte/half/word load-store controller with read-modify-write sub-word stores.
// Optional DMEM_ALIGN_CHECK_EN: misaligned half/word accesses complete early with err.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int WORDS = 256
) (
  input  logic       clk,
  input  logic       rst,
  dmem_ctrl_if.slave bus
);
  localparam int IW = $clog2(WORDS);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q, merged_q, rdata_q;
  logic              done_q, busy_q, err_q;

  logic              accept, misal;
  logic              ram_we;
  logic [IW-1:0]     ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic [4:0]        sh;
  logic [31:0]       lane_d, load_d, mask_d, merge_d;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misal = misaligned(bus.size, bus.addr[1:0]);
`else
  assign misal = 1'b0;
`endif

  assign accept = (state_q == ST_IDLE) && bus.req;

  // Word stores write on the sampling edge; sub-word stores write from RMW_WR.
  assign ram_we    = (accept && !bus.cs && bus.we && bus.size[1] && !misal)
                   || (state_q == ST_RMW_WR);
  assign ram_addr  = (state_q == ST_IDLE) ? bus.addr[IW+1:2] : addr_q[IW+1:2];
  assign ram_wdata = (state_q == ST_RMW_WR) ? merged_q : bus.wdata;

  dmem_ram #(.WORDS(WORDS)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    sh = 5'd0;
    if (size_q == SZ_HALF)      sh = {addr_q[1], 4'b0};
    else if (size_q == SZ_BYTE) sh = {addr_q[1:0], 3'b0};
    lane_d = ram_rdata >> sh;
    mask_d = ((size_q == SZ_HALF) ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    merge_d = (ram_rdata & ~mask_d) | ((wdata_q << sh) & mask_d);
    if (size_q == SZ_BYTE)      load_d = {{24{!uns_q && lane_d[7]}}, lane_d[7:0]};
    else if (size_q == SZ_HALF) load_d = {{16{!uns_q && lane_d[15]}}, lane_d[15:0]};
    else                        load_d = ram_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      size_q   <= SZ_BYTE;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (bus.req) begin
          addr_q  <= bus.addr;
          size_q  <= bus.size;
          uns_q   <= bus.uns;
          wdata_q <= bus.wdata;
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
          if (bus.cs || misal) begin
            err_q   <= misal && !bus.cs;
            rdata_q <= '0;
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else if (!bus.we) begin
            state_q <= ST_RD;
          end else if (bus.size[1]) begin
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            state_q <= ST_RMW_RD;
          end
        end
        ST_RD: begin
          rdata_q <= load_d;
          done_q  <= 1'b1;
          state_q <= ST_FIN;
        end
        ST_RMW_RD: begin
          merged_q <= merge_d;
          state_q  <= ST_RMW_WR;
        end
        ST_RMW_WR: begin
          done_q  <= 1'b1;
          state_q <= ST_FIN;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: word-level memory model, random and directed accesses.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_ctrl_if bus();
  dmem_ctrl #(.WORDS(256)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] mem [256];
  logic [31:0] m_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop on every done, and flag responses that never arrive.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious done: got done=1 expected no pending access");
        end else begin
          exp_t e;
          e = q.pop_front();
          check({e.name, " rdata"}, bus.rdata, e.rdata);
          check({e.name, " err"}, {31'b0, bus.err}, {31'b0, e.err});
          check({e.name, " latency"}, cyc - e.t0, e.lat);
        end
      end else if (q.size() > 0 && (cyc - q[0].t0) > 20) begin
        checks++; errors++;
        $display("FAIL %s timeout: got no done expected done", q[0].name);
        void'(q.pop_front());
      end
    end
  end

  task automatic wait_idle(string nm);
    int n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL %s busy timeout: got busy=1 expected 0", nm);
    end
  endtask

  task automatic issue(string nm, bit cs, bit we, logic [9:0] a, logic [1:0] sz,
                       bit uns, logic [31:0] wd);
    exp_t        e;
    logic [31:0] w, v, msk;
    int          sh;
    bit          mis, is_word;
    wait_idle(nm);
    bus.req = 1'b1; bus.cs = cs; bus.we = we; bus.addr = a;
    bus.size = sz;  bus.uns = uns; bus.wdata = wd;

    is_word = (sz == SZ_WORD) || (sz == 2'b11);
    sh  = (sz == SZ_BYTE) ? 8 * int'(a[1:0]) : (sz == SZ_HALF) ? 16 * int'(a[1]) : 0;
    mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (sz == SZ_HALF && a[0]) || (is_word && a[1:0] != 2'b00);
`endif
    e.err = 1'b0;
    if (cs) begin
      m_rdata = '0; e.lat = 1;
    end else if (mis) begin
      m_rdata = '0; e.err = 1'b1; e.lat = 1;
    end else if (!we) begin
      w = mem[a[9:2]];
      e.lat = 2;
      if (sz == SZ_BYTE) begin
        v = (w >> sh) & 32'hFF;
        if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == SZ_HALF) begin
        v = (w >> sh) & 32'hFFFF;
        if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      m_rdata = v;
    end else if (is_word) begin
      mem[a[9:2]] = wd; e.lat = 1;
    end else begin
      msk = ((sz == SZ_BYTE) ? 32'hFF : 32'hFFFF) << sh;
      mem[a[9:2]] = (mem[a[9:2]] & ~msk) | ((wd << sh) & msk);
      e.lat = 3;
    end
    e.rdata = m_rdata;
    e.t0    = cyc;
    e.name  = nm;
    q.push_back(e);
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.req = 0; bus.cs = 0; bus.we = 0; bus.addr = '0;
    bus.size = SZ_WORD; bus.uns = 0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("reset rdata", bus.rdata, 32'h0);
    check("reset done", {31'b0, bus.done}, 32'h0);
    check("reset busy", {31'b0, bus.busy}, 32'h0);
    check("reset err", {31'b0, bus.err}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++)
      issue("preload", 0, 1, 10'(i * 4), SZ_WORD, 0, $urandom);

    issue("tp word st", 0, 1, 10'h010, SZ_WORD, 0, 32'hDEAD_BEEF);
    issue("tp word ld", 0, 0, 10'h010, SZ_WORD, 0, '0);
    issue("tp st 0x020", 0, 1, 10'h020, SZ_WORD, 0, 32'h1122_3344);
    issue("tp byte rmw", 0, 1, 10'h021, SZ_BYTE, 0, 32'h0000_00AA);
    issue("tp rmw word", 0, 0, 10'h020, SZ_WORD, 0, '0);
    issue("tp lb", 0, 0, 10'h021, SZ_BYTE, 0, '0);
    issue("tp lbu", 0, 0, 10'h021, SZ_BYTE, 1, '0);
    issue("tp st 0x040", 0, 1, 10'h040, SZ_WORD, 0, 32'h8001_7FFF);
    issue("tp lh hi", 0, 0, 10'h042, SZ_HALF, 0, '0);
    issue("tp lh lo", 0, 0, 10'h040, SZ_HALF, 0, '0);
    issue("tp oow st", 1, 1, 10'h010, SZ_WORD, 0, 32'h1234_5678);
    issue("tp oow reread", 0, 0, 10'h010, SZ_WORD, 0, '0);
    issue("tp misal lw", 0, 0, 10'h003, SZ_WORD, 0, '0);
    issue("tp misal lh", 0, 0, 10'h041, SZ_HALF, 1, '0);
    issue("tp size11 ld", 0, 0, 10'h040, 2'b11, 0, '0);

    // Abort a byte store while it sits in RMW_RD.
    wait_idle("rst rmw");
    bus.req = 1; bus.cs = 0; bus.we = 1; bus.addr = 10'h021;
    bus.size = SZ_BYTE; bus.uns = 0; bus.wdata = 32'h55;
    @(negedge clk);
    bus.req = 0;
    rst = 1'b1;
    #1;
    check("rst rmw rdata", bus.rdata, 32'h0);
    check("rst rmw done", {31'b0, bus.done}, 32'h0);
    check("rst rmw busy", {31'b0, bus.busy}, 32'h0);
    check("rst rmw err", {31'b0, bus.err}, 32'h0);
    m_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    issue("rst rmw reread", 0, 0, 10'h020, SZ_WORD, 0, '0);

    for (int i = 0; i < 300; i++)
      issue("rand", ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
            10'($urandom_range(0, 127)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 1), $urandom);

    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
